// File: rtl/pong_pkg.sv
// Shared screen geometry, accumulator widths and tracker state encoding for the
// pong camera-paddle path.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int CNT_W    = 14;
    localparam int SUM_W    = 23;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_UPDATE = 2'd2
    } tracker_state_e;

    // Keeps the whole paddle on screen: centre row limited to [lo, hi].
    function automatic logic [COORD_W-1:0] clamp_row(input logic [SUM_W-1:0] q,
                                                     input int lo,
                                                     input int hi);
        if (int'(q) < lo) return COORD_W'(lo);
        if (int'(q) > hi) return COORD_W'(hi);
        return COORD_W'(q);
    endfunction

endpackage

// File: rtl/paddle_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done_o marks the cycle
// in which quotient_o carries the final (floored) result.
module seq_divider
    import pong_pkg::*;
#(
    parameter int DVD_W = SUM_W,
    parameter int DVS_W = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o
);

    localparam int STEP_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0]  rem_q, rem_d;
    logic [DVD_W-1:0]  quot_q, quot_d;
    logic [DVS_W-1:0]  divisor_q, divisor_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;

    logic [DVS_W:0]    rem_shift;
    logic [DVS_W:0]    trial;
    logic              fits;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rem_shift = {rem_q, quot_q[DVD_W-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        fits      = (rem_shift >= {1'b0, divisor_q});

        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        step_d    = step_q;
        busy_d    = busy_q;

        if (start_i) begin
            rem_d     = '0;
            quot_d    = dividend_i;
            divisor_d = divisor_i;
            step_d    = '0;
            busy_d    = 1'b1;
        end else if (busy_q) begin
            rem_d  = fits ? trial[DVS_W-1:0] : rem_shift[DVS_W-1:0];
            quot_d = {quot_q[DVD_W-2:0], fits};
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(DVD_W - 1)) busy_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (step_q == STEP_W'(DVD_W - 1));
    assign quotient_o = {quot_q[DVD_W-2:0], fits};

endmodule

// File: rtl/paddle_tracker.sv
// Tracks the paddle centre row from thresholded camera pixels: averages the rows
// of set pixels inside a column band once per frame during vertical blank.
module paddle_tracker
    import pong_pkg::*;
#(
    parameter int COL_LO      = 10,
    parameter int COL_HI      = 29,
    parameter int MIN_COUNT   = 64,
    parameter int PADDLE_HALF = 40,
    parameter int Y_RESET     = 240
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               blank,
    input  logic               pixel_on,
    output logic [COORD_W-1:0] PaddleY,
    output logic               track_valid,
    output logic               frame_done,
    output logic               busy
);

    tracker_state_e       state_q, state_d;
    logic [2*COORD_W-1:0] prev_xy_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [COORD_W-1:0]   paddle_q, paddle_d;
    logic                 valid_q, valid_d;

    logic                 new_px;
    logic                 in_band;
    logic                 qualify;
    logic                 capture;
    logic                 cnt_ok;
    logic                 div_done;
    logic [SUM_W-1:0]     quotient;

    // DrawX is held for two clocks; only the first cycle of each coordinate counts.
    assign new_px  = ({DrawX, DrawY} != prev_xy_q);
    assign in_band = (DrawX >= COORD_W'(COL_LO)) && (DrawX <= COORD_W'(COL_HI));
    assign qualify = (state_q == ST_ACCUM) && new_px && blank && pixel_on && in_band
                     && (DrawY < COORD_W'(SCREEN_H));
    assign capture = (state_q == ST_ACCUM) && new_px
                     && (DrawY == COORD_W'(SCREEN_H))
                     && (prev_xy_q[COORD_W-1:0] == COORD_W'(SCREEN_H - 1));
    assign cnt_ok  = (cnt_q >= CNT_W'(MIN_COUNT));

    seq_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .start_i    (capture && cnt_ok),
        .dividend_i (sum_q),
        .divisor_i  (cnt_q),
        .busy_o     (),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:  if (capture) state_d = cnt_ok ? ST_DIVIDE : ST_UPDATE;
            ST_DIVIDE: if (div_done) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_ACCUM;
            default:   state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_ACCUM);
        frame_done = (state_q == ST_UPDATE);
    end

    // Results are loaded on the edge entering UPDATE so they are visible with frame_done.
    always_comb begin
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        paddle_d = paddle_q;
        valid_d  = valid_q;

        if (capture) begin
            cnt_d = '0;
            sum_d = '0;
            if (!cnt_ok) valid_d = 1'b0;
        end else if (qualify) begin
            cnt_d = cnt_q + 1'b1;
            sum_d = sum_q + SUM_W'(DrawY);
        end

        if ((state_q == ST_DIVIDE) && div_done) begin
            paddle_d = clamp_row(quotient, PADDLE_HALF, SCREEN_H - 1 - PADDLE_HALF);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_xy_q <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            paddle_q  <= COORD_W'(Y_RESET);
            valid_q   <= 1'b0;
        end else begin
            prev_xy_q <= {DrawX, DrawY};
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            paddle_q  <= paddle_d;
            valid_q   <= valid_d;
        end
    end

    assign PaddleY     = paddle_q;
    assign track_valid = valid_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Scoreboard bench for paddle_tracker: a raster driver feeds compressed frames and
// queues the expected per-frame result; a monitor checks every frame_done pulse.
module tb_paddle_tracker;

    localparam int COL_LO      = 10;
    localparam int COL_HI      = 29;
    localparam int MIN_COUNT   = 64;
    localparam int PADDLE_HALF = 40;
    localparam int Y_RESET     = 240;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       blank, pixel_on;
    logic [9:0] PaddleY;
    logic       track_valid, frame_done, busy;

    paddle_tracker #(
        .COL_LO      (COL_LO),
        .COL_HI      (COL_HI),
        .MIN_COUNT   (MIN_COUNT),
        .PADDLE_HALF (PADDLE_HALF),
        .Y_RESET     (Y_RESET)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .pixel_on    (pixel_on),
        .PaddleY     (PaddleY),
        .track_valid (track_valid),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct {
        int paddle;
        bit valid;
        int fe_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   model_paddle = Y_RESET;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every frame_done cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (frame_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("paddle_y", PaddleY, e.paddle);
                    check("track_valid", track_valid, e.valid);
                    check("latency_le_25", (cyc - e.fe_cyc <= 25) ? 1 : 0, 1);
                    check("busy_at_frame_done", busy, 1);
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge Clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int x, input int y, input bit on, input bit blk);
        @(negedge Clk);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        pixel_on = on;
        blank    = blk;
        @(negedge Clk);
    endtask

    function automatic bit in_band(input int x);
        return (x >= COL_LO) && (x <= COL_HI);
    endfunction

    // One frame: rows lo..hi lit in the band; stop_row < 480 resets mid-frame instead
    // of finishing; abort_div resets ten cycles into the division.
    task automatic run_frame(input int lo, input int hi, input bit noise, input bit blank_band,
                             input bit col100_on, input int stop_row, input bit abort_div);
        bit     visit [0:479];
        int     mcnt;
        longint msum;
        int     x, q, fe;
        bit     on, blk;
        exp_t   e;

        mcnt = 0;
        msum = 0;
        for (int y = 0; y < 480; y++) visit[y] = (y >= lo && y <= hi) || y == 0 || y == 479;
        repeat (5) visit[$urandom_range(0, 479)] = 1'b1;

        for (int y = 0; y < 480; y++) begin
            if (y == stop_row) begin
                @(negedge Clk);
                Reset = 1'b1;
                repeat (2) @(negedge Clk);
                Reset = 1'b0;
                model_paddle = Y_RESET;
                check("partial_reset_paddle", PaddleY, Y_RESET);
                return;
            end
            if (visit[y]) begin
                for (int k = 0; k < 23; k++) begin
                    x   = (k < 22) ? COL_LO - 1 + k : 100;
                    on  = in_band(x) ? (y >= lo && y <= hi) : col100_on;
                    blk = !(blank_band && in_band(x));
                    if (noise) begin
                        if ($urandom_range(0, 15) == 0) on = !on;
                        if ($urandom_range(0, 15) == 0) blk = 1'b0;
                    end
                    drive(x, y, on, blk);
                    if (on && blk && in_band(x)) begin
                        mcnt++;
                        msum += y;
                    end
                end
            end
        end

        @(negedge Clk);
        DrawX    = 10'd0;
        DrawY    = 10'd480;
        blank    = 1'b0;
        pixel_on = 1'b0;
        fe       = cyc;

        if (mcnt >= MIN_COUNT) begin
            q = int'(msum / longint'(mcnt));
            if (q < PADDLE_HALF) q = PADDLE_HALF;
            if (q > 479 - PADDLE_HALF) q = 479 - PADDLE_HALF;
            e.valid = 1'b1;
            e.paddle = q;
        end else begin
            e.valid = 1'b0;
            e.paddle = model_paddle;
        end
        e.fe_cyc = fe;

        if (abort_div) begin
            repeat (10) @(negedge Clk);
            check("busy_in_divide", busy, 1);
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
            check("abort_paddle", PaddleY, Y_RESET);
            check("abort_valid", track_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_frame_done", frame_done, 0);
            model_paddle = Y_RESET;
        end else begin
            exp_q.push_back(e);
            model_paddle = e.paddle;
        end

        repeat (40) @(negedge Clk);
        check("frame_done_seen", exp_q.size(), 0);
        DrawY = 10'd481;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset    = 1'b1;
        DrawX    = '0;
        DrawY    = '0;
        blank    = 1'b0;
        pixel_on = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("reset_paddle", PaddleY, Y_RESET);
        check("reset_valid", track_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);

        run_frame(200, 279, 0, 0, 0, 999, 0);
        run_frame(200, 202, 0, 0, 0, 999, 0);
        run_frame(0, 19, 0, 0, 0, 999, 0);
        run_frame(460, 479, 0, 0, 0, 999, 0);
        run_frame(200, 219, 0, 1, 1, 999, 0);
        run_frame(200, 279, 0, 0, 0, 999, 1);
        run_frame(200, 279, 0, 0, 0, 999, 0);
        run_frame(200, 279, 0, 0, 0, 240, 0);
        run_frame(300, 379, 0, 0, 0, 999, 0);
        run_frame(100, 179, 0, 0, 0, 999, 0);
        run_frame(300, 379, 0, 0, 0, 999, 0);
        for (int i = 0; i < 3; i++) begin
            int lo;
            lo = $urandom_range(0, 440);
            run_frame(lo, lo + $urandom_range(3, 39), 1, 0, 0, 999, 0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paddle_tracker.md
PADDLE_TRACKER -- requirements
Module: paddle_tracker

Interface
REQ-001 Parameter COL_LO, default 10: first DrawX column of the tracking band, inclusive.
REQ-002 Parameter COL_HI, default 29: last DrawX column of the tracking band, inclusive; COL_HI-COL_LO+1 SHALL be <= 32.
REQ-003 Parameter MIN_COUNT, default 64: minimum set-pixel count for a valid frame.
REQ-004 Parameter PADDLE_HALF, default 40: half paddle height, used for clamping.
REQ-005 Parameter Y_RESET, default 240: PaddleY value after reset.
REQ-006 Clk  in  1: 50 MHz system clock; one clock domain; all logic on posedge Clk.
REQ-007 Reset  in  1: synchronous, active-high reset.
REQ-008 DrawX  in  10: current VGA column, changes every 2 Clk cycles.
REQ-009 DrawY  in  10: current VGA row.
REQ-010 blank  in  1: active-low blanking; 1 = visible pixel.
REQ-011 pixel_on  in  1: thresholded camera bit for (DrawX, DrawY).
REQ-012 PaddleY  out  10: centre row of the paddle, clamped.
REQ-013 track_valid  out  1: 1 = the last completed frame met MIN_COUNT.
REQ-014 frame_done  out  1: single-cycle pulse when PaddleY/track_valid update.
REQ-015 busy  out  1: high while in DIVIDE or UPDATE.

Function
REQ-016 new_px SHALL be asserted in a cycle where {DrawX,DrawY} differs from its value registered one cycle earlier, so each pixel is counted once.
REQ-017 Qualifying pixel: new_px & blank & pixel_on & COL_LO<=DrawX<=COL_HI & DrawY<480.
REQ-018 Per qualifying pixel: cnt (14 b) += 1; sum (23 b) += DrawY; no overflow is possible within REQ-002 limits.
REQ-019 Frame end: new_px with DrawY==480 while previous registered DrawY==479.
REQ-020 FSM states ACCUM, DIVIDE, UPDATE; reset state ACCUM.
REQ-021 ACCUM->DIVIDE at frame end: cnt/sum captured into the divider and cleared in the same cycle; a qualifying pixel in that cycle is impossible (DrawY==480).
REQ-022 If the captured cnt < MIN_COUNT: skip the division, go directly to UPDATE with invalid result.
REQ-023 DIVIDE: restoring divide sum/cnt, 1 quotient bit per cycle, 23 cycles, quotient floored; then -> UPDATE.
REQ-024 UPDATE, valid result: PaddleY = quotient clamped to [PADDLE_HALF, 479-PADDLE_HALF]; track_valid=1.
REQ-025 UPDATE, invalid result: PaddleY holds its previous value; track_valid=0.
REQ-026 UPDATE: frame_done=1 for exactly this cycle, then -> ACCUM; total latency from frame end to frame_done <= 25 cycles.
REQ-027 Pixels arriving during DIVIDE/UPDATE are impossible (vertical blank); no qualifying pixel is dropped in ACCUM.
REQ-028 PaddleY SHALL change only in UPDATE or reset; it is stable for the whole visible frame.

Reset
REQ-029 On Reset: state=ACCUM, cnt=0, sum=0, divider cleared, PaddleY=Y_RESET, track_valid=0, frame_done=0, busy=0, previous-coordinate register=0.
REQ-030 Reset mid-DIVIDE/UPDATE aborts the operation with no frame_done pulse; the next complete frame is processed normally.
REQ-031 A frame partially accumulated before reset release is discarded; the counts restart from 0.

Structure
REQ-032 Package pong_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, coordinate width 10, CNT_W=14, SUM_W=23, and the tracker state enum.
REQ-033 Sub-module seq_divider (SUM_W/CNT_W, start/done handshake, restoring) SHALL perform REQ-023.
REQ-034 No RAM; the block replaces the column buffer plus combinational centre logic feeding ball's PaddleY.

Verification
REQ-035 Set rows 200..279, cols 10..29, each pixel held 2 cycles -> cnt=1600, PaddleY=239, track_valid=1, one frame_done pulse <=25 cycles after DrawY reaches 480.
REQ-036 Only 3 rows set (60 px) after a valid frame at 239 -> PaddleY stays 239, track_valid=0, frame_done pulses.
REQ-037 Rows 0..19 set in the band -> quotient 9 -> PaddleY=40; rows 460..479 -> PaddleY=439.
REQ-038 pixel_on=1 at DrawX=100 everywhere plus blank=0 over the band -> cnt=0, track_valid=0.
REQ-039 Reset asserted on DIVIDE cycle 10 -> next cycle PaddleY=240, track_valid=0, busy=0, no frame_done; the next frame with rows 200..279 yields 239.
REQ-040 Two consecutive frames with different blocks (rows 100..179, then 300..379) -> PaddleY 139, then 339; accumulators show no carry-over.
